// File: rtl/sync_up_counter_t.sv
// ============================================================================
// sync_up_counter_t : modulo-MOD synchronous up counter built from T flip-flops
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_up_counter_t #(
  parameter int WIDTH = 4,
  parameter int MOD   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MOD - 1);
  localparam logic [WIDTH:0]   C_MOD = (WIDTH + 1)'(MOD);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] toggle;
  logic             carry;
  logic             at_max;
  logic             load_ok;
  logic             wrap_d;
  logic             wrap_q;
  logic             load_err_d;
  logic             load_err_q;

  assign at_max  = (count_q == C_MAX);
  assign load_ok = ({1'b0, load_val} < C_MOD);

  // Loads become a toggle mask (old ^ new); at MOD-1 every set bit toggles to reach 0.
  always_comb begin
    toggle = '0;
    carry  = 1'b1;
    if (load) begin
      if (load_ok) begin
        toggle = count_q ^ load_val;
      end
    end else if (en) begin
      if (at_max) begin
        toggle = count_q;
      end else begin
        for (int i = 0; i < WIDTH; i++) begin
          toggle[i] = carry;
          carry     = carry & count_q[i];
        end
      end
    end
  end

  for (genvar b = 0; b < WIDTH; b++) begin : g_tff
    logic bit_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        bit_q <= 1'b0;
      end else if (toggle[b]) begin
        bit_q <= ~bit_q;
      end
    end
    assign count_q[b] = bit_q;
  end

  assign wrap_d     = en & ~load & at_max;
  assign load_err_d = load & ~load_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign count    = count_q;
  assign tc       = en & at_max;
  assign wrap     = wrap_q;
  assign load_err = load_err_q;

endmodule

`default_nettype wire

// File: tb/tb_sync_up_counter_t.sv
// ============================================================================
// tb_sync_up_counter_t : table, directed and random checks for MOD 16/10/2
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sync_up_counter_t;

  logic       clk;
  logic       rst;
  logic       en;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] cnt_o [3];
  logic       tc_o  [3];
  logic       wrap_o[3];
  logic       err_o [3];

  int checks   = 0;
  int failures = 0;

  int   m_cnt [3];
  bit   m_wrap[3];
  bit   m_err [3];
  logic tc_smp[3];

  sync_up_counter_t #(.WIDTH(4), .MOD(16)) u_m16 (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
    .count(cnt_o[0]), .tc(tc_o[0]), .wrap(wrap_o[0]), .load_err(err_o[0])
  );
  sync_up_counter_t #(.WIDTH(4), .MOD(10)) u_m10 (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
    .count(cnt_o[1]), .tc(tc_o[1]), .wrap(wrap_o[1]), .load_err(err_o[1])
  );
  sync_up_counter_t #(.WIDTH(4), .MOD(2)) u_m2 (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
    .count(cnt_o[2]), .tc(tc_o[2]), .wrap(wrap_o[2]), .load_err(err_o[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int mod_of(input int i);
    case (i)
      0:       return 16;
      1:       return 10;
      default: return 2;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // One clock: drive inputs, check tc before the edge, advance the model, check registered outputs.
  task automatic step(input logic r, input logic e, input logic l, input logic [3:0] lv,
                      input bit chk_tc);
    rst = r; en = e; load = l; load_val = lv;
    #1;
    for (int i = 0; i < 3; i++) begin
      tc_smp[i] = tc_o[i];
      if (chk_tc)
        chk($sformatf("model_tc_mod%0d", mod_of(i)), 32'(tc_o[i]),
            32'(e && (m_cnt[i] == mod_of(i) - 1)));
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (r) begin
        m_cnt[i] = 0; m_wrap[i] = 0; m_err[i] = 0;
      end else if (l) begin
        m_wrap[i] = 0;
        m_err[i]  = (int'(lv) >= mod_of(i));
        if (!m_err[i]) m_cnt[i] = int'(lv);
      end else if (e) begin
        m_wrap[i] = (m_cnt[i] == mod_of(i) - 1);
        m_cnt[i]  = (m_cnt[i] + 1) % mod_of(i);
        m_err[i]  = 0;
      end else begin
        m_wrap[i] = 0; m_err[i] = 0;
      end
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("model_count_mod%0d", mod_of(i)), 32'(cnt_o[i]), 32'(m_cnt[i]));
      chk($sformatf("model_wrap_mod%0d",  mod_of(i)), 32'(wrap_o[i]), 32'(m_wrap[i]));
      chk($sformatf("model_lerr_mod%0d",  mod_of(i)), 32'(err_o[i]),  32'(m_err[i]));
    end
  endtask

  typedef struct {
    logic       r, e, l;
    logic [3:0] lv;
    logic       tc16, tc10;
    int         c16, c10;
    logic       w16, w10, e16, e10;
  } vec_t;

  vec_t tbl[16];

  initial begin
    //          r  e  l  lv  tc16 tc10 c16 c10 w16 w10 e16 e10
    tbl[0]  = '{0, 1, 1, 5,  0,   0,   5,  5,  0,  0,  0,  0};
    tbl[1]  = '{0, 1, 1, 12, 0,   0,   12, 5,  0,  0,  0,  1};
    tbl[2]  = '{0, 0, 1, 3,  0,   0,   3,  3,  0,  0,  0,  0};
    tbl[3]  = '{0, 1, 1, 4,  0,   0,   4,  4,  0,  0,  0,  0};
    tbl[4]  = '{0, 0, 1, 11, 0,   0,   11, 4,  0,  0,  0,  1};
    tbl[5]  = '{0, 0, 0, 0,  0,   0,   11, 4,  0,  0,  0,  0};
    tbl[6]  = '{0, 1, 1, 7,  0,   0,   7,  7,  0,  0,  0,  0};
    tbl[7]  = '{0, 1, 0, 0,  0,   0,   8,  8,  0,  0,  0,  0};
    tbl[8]  = '{0, 0, 0, 0,  0,   0,   8,  8,  0,  0,  0,  0};
    tbl[9]  = '{0, 1, 0, 0,  0,   0,   9,  9,  0,  0,  0,  0};
    tbl[10] = '{0, 0, 0, 0,  0,   0,   9,  9,  0,  0,  0,  0};
    tbl[11] = '{0, 1, 0, 0,  0,   1,   10, 0,  0,  1,  0,  0};
    tbl[12] = '{0, 0, 1, 15, 0,   0,   15, 0,  0,  0,  0,  1};
    tbl[13] = '{1, 1, 0, 0,  1,   0,   0,  0,  0,  0,  0,  0};
    tbl[14] = '{0, 0, 0, 0,  0,   0,   0,  0,  0,  0,  0,  0};
    tbl[15] = '{1, 1, 1, 12, 0,   0,   0,  0,  0,  0,  0,  0};

    rst = 1'b1; en = 1'b0; load = 1'b0; load_val = '0;
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_wrap[i] = 0; m_err[i] = 0;
    end
    step(1, 1, 1, 4'd9, 0);
    step(1, 0, 0, 4'd0, 1);
    for (int i = 0; i < 3; i++)
      chk($sformatf("reset_count_mod%0d", mod_of(i)), 32'(cnt_o[i]), 32'd0);

    for (int n = 0; n < 16; n++) begin
      step(tbl[n].r, tbl[n].e, tbl[n].l, tbl[n].lv, 1);
      chk($sformatf("tbl%0d_tc16", n),  32'(tc_smp[0]), 32'(tbl[n].tc16));
      chk($sformatf("tbl%0d_tc10", n),  32'(tc_smp[1]), 32'(tbl[n].tc10));
      chk($sformatf("tbl%0d_c16", n),   32'(cnt_o[0]),  32'(tbl[n].c16));
      chk($sformatf("tbl%0d_c10", n),   32'(cnt_o[1]),  32'(tbl[n].c10));
      chk($sformatf("tbl%0d_w16", n),   32'(wrap_o[0]), 32'(tbl[n].w16));
      chk($sformatf("tbl%0d_w10", n),   32'(wrap_o[1]), 32'(tbl[n].w10));
      chk($sformatf("tbl%0d_err16", n), 32'(err_o[0]),  32'(tbl[n].e16));
      chk($sformatf("tbl%0d_err10", n), 32'(err_o[1]),  32'(tbl[n].e10));
    end

    // Free-running from reset: full sequences and wrap spacing for each modulus.
    step(1, 0, 0, 4'd0, 1);
    for (int k = 0; k < 20; k++) begin
      step(0, 1, 0, 4'd0, 1);
      chk($sformatf("run%0d_c16", k),  32'(cnt_o[0]),  32'((k + 1) % 16));
      chk($sformatf("run%0d_c10", k),  32'(cnt_o[1]),  32'((k + 1) % 10));
      chk($sformatf("run%0d_c2", k),   32'(cnt_o[2]),  32'((k + 1) % 2));
      chk($sformatf("run%0d_tc16", k), 32'(tc_smp[0]), 32'(k % 16 == 15));
      chk($sformatf("run%0d_w16", k),  32'(wrap_o[0]), 32'(k % 16 == 15));
      chk($sformatf("run%0d_w10", k),  32'(wrap_o[1]), 32'(k % 10 == 9));
      chk($sformatf("run%0d_w2", k),   32'(wrap_o[2]), 32'(k % 2 == 1));
    end

    for (int k = 0; k < 600; k++) begin
      step($urandom_range(0, 29) == 0, $urandom_range(0, 9) < 6,
           $urandom_range(0, 4) == 0, 4'($urandom_range(0, 15)), 1);
      chk("rand_c10_range", 32'(cnt_o[1] < 4'd10), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/sync_up_counter_t.md
SYNC_UP_COUNTER_T -- requirements
Module: sync_up_counter_t

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning counter width in bits (legal range 2..16).
REQ-002 SHALL have parameter MOD, default 16, meaning count modulus; count sequence is 0..MOD-1, with legal range 2..2**WIDTH.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port en  input  1  count enable; advances count by one per enabled edge.
REQ-006 SHALL have port load  input  1  parallel-load request.
REQ-007 SHALL have port load_val  input  WIDTH  value to load.
REQ-008 SHALL have port count  output  WIDTH  current count, driven directly from the bit flip-flops.
REQ-009 SHALL have port tc  output  1  terminal count (combinational): en high and count == MOD-1.
REQ-010 SHALL have port wrap  output  1  registered one-cycle pulse, asserted on the cycle after count rolls MOD-1 -> 0.
REQ-011 SHALL have port load_err  output  1  registered one-cycle pulse flagging a rejected load.

Function
REQ-012 SHALL hold each count bit in a T flip-flop clocked by clk, with no derived or ripple clocks.
REQ-013 SHALL set T of bit i to en AND (all bits below i == 1) during normal counting, so the result counts upward.
REQ-014 SHALL have, at count == MOD-1 with en high, every set bit toggle so that the next count is 0, for any MOD including non-powers of two.
REQ-015 SHALL apply per-edge priority rst > load > en.
REQ-016 SHALL, when load is high and load_val < MOD: count <= load_val, ignore en that cycle, and leave wrap at 0.
REQ-017 SHALL, when load is high and load_val >= MOD: hold count, pulse load_err high for exactly the next cycle, and ignore en that cycle.
REQ-018 SHALL, when en is low and load is low: hold count, with tc low and wrap low on the next cycle.
REQ-019 SHALL keep tc purely combinational, so tc is high in the same cycle the wrapping edge is pending.
REQ-020 SHALL assert wrap for exactly one cycle per rollover; back-to-back rollovers (MOD=2, en held high) produce wrap high on alternate cycles.
REQ-021 SHALL keep count always within 0..MOD-1 after reset; no reachable illegal state.
REQ-022 SHALL have latency of one clock from en/load sampling to updated count.

Reset
REQ-023 SHALL, when rst is high at a rising edge, drive count=0, wrap=0, load_err=0 after that edge, regardless of en and load.
REQ-024 SHALL make tc low while count=0 after reset (for MOD>1).
REQ-025 SHALL abort any pending wrap/load_err pulse when rst is asserted mid-operation; the pulse is not emitted.
REQ-026 SHALL have no effect from rst between edges (synchronous only).

Verification
REQ-027 SHALL cover: WIDTH=4, MOD=16, rst one cycle, en=1 for 17 cycles -> count 0,1,...,15,0,1; tc high only at count 15; wrap high only the cycle count shows 0 after 15.
REQ-028 SHALL cover: MOD=10, en=1 from reset -> count 0..9,0; count never shows 10..15; wrap pulses once every 10 enabled cycles.
REQ-029 SHALL cover: count=5, load=1, load_val=12, en=1 (MOD=16) -> count=12 next cycle, not 6; then load=1, load_val=3 with MOD=10 -> count=3.
REQ-030 SHALL cover: MOD=10, count=4, load=1, load_val=11 -> count stays 4, load_err=1 for one cycle, then 0.
REQ-031 SHALL cover: count=15, en=1, rst=1 on same edge (MOD=16) -> count=0, wrap stays 0 on the following cycle.
REQ-032 SHALL cover: en toggled 1,0,1,0 from count=7 -> count 8,8,9,9; tc low throughout; no wrap.
